wb_arbiter: RTL and testbench

Writeback-side driver of the register file write port (rd/wdata/RegWrite). Merges single-cycle ALU results with results from long-latency units (load, mul/div) into one write per cycle. Long-latency results are buffered in a small FIFO. A per-register pending scoreboard tells issue logic which registers still await a long-latency write.

---
 rtl/wb_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results with FIFO-buffered long-latency results
// into one registered register-file write per cycle, plus a pending scoreboard.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [4:0]    a_rd,
  input  logic [31:0]   a_wdata,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [4:0]    b_rd,
  input  logic [31:0]   b_wdata,
  input  logic          iss_valid,
  input  logic [4:0]    iss_rd,
  input  logic [4:0]    chk_rs1,
  input  logic [4:0]    chk_rs2,
  output logic          hz_rs1,
  output logic          hz_rs2,
  output logic [4:0]    rf_rd,
  output logic [31:0]   rf_wdata,
  output logic          rf_we,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [36:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pend_q, pend_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_rd_q, rf_rd_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;

  logic        full, empty, push, pop, a_sel;
  logic [36:0] head;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == CW'(0));
  assign b_ready = ~full & ~reset;
  // rd==0 pushes complete the handshake but are never stored.
  assign push    = b_valid & b_ready & (b_rd != 5'd0);
  assign a_sel   = a_valid & (a_rd != 5'd0);
  assign pop     = ~a_sel & ~empty;
  assign head    = mem_q[rd_ptr_q];

  assign hz_rs1     = pend_q[chk_rs1];
  assign hz_rs2     = pend_q[chk_rs2];
  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wdata   = rf_wdata_q;
  assign fifo_count = count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pend_d     = pend_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      pend_d[head[36:32]] = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    // Applied after the pop clear so a same-register issue wins.
    if (iss_valid && (iss_rd != 5'd0)) begin
      pend_d[iss_rd] = 1'b1;
    end else begin
      pend_d[0] = 1'b0;
    end
    pend_d[0] = 1'b0;

    if (a_sel) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = a_rd;
      rf_wdata_d = a_wdata;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = head[36:32];
      rf_wdata_d = head[31:0];
    end else begin
      rf_we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {b_rd, b_wdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pend_q     <= 32'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic reset;
  logic a_valid, b_valid, iss_valid, b_ready, hz_rs1, hz_rs2, rf_we;
  logic [4:0] a_rd, b_rd, iss_rd, chk_rs1, chk_rs2, rf_rd;
  logic [31:0] a_wdata, b_wdata, rf_wdata;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered queue of pending B results plus expected outputs.
  logic [36:0] mq[$];
  bit          mpend[32];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rd(a_rd), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_wdata(b_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hz_rs1(hz_rs1), .hz_rs2(hz_rs2),
    .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_we(rf_we), .fifo_count(fifo_count)
  );

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
    m_we = 1'b0; m_rd = 5'd0; m_wd = 32'd0;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_rd = 5'd0; a_wdata = 32'd0;
    b_valid = 1'b0; b_rd = 5'd0; b_wdata = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
  endtask

  // One clock: the model applies the writeback rules to the pre-edge state.
  task automatic cycle();
    bit ready, a_sel, pop;
    logic [36:0] h;
    ready = (mq.size() < DEPTH);
    a_sel = a_valid && (a_rd != 5'd0);
    pop   = !a_sel && (mq.size() > 0);
    @(posedge clk);
    if (a_sel) begin
      m_we = 1'b1; m_rd = a_rd; m_wd = a_wdata;
    end else if (pop) begin
      h = mq.pop_front();
      m_we = 1'b1; m_rd = h[36:32]; m_wd = h[31:0];
      mpend[h[36:32]] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (b_valid && ready && (b_rd != 5'd0)) mq.push_back({b_rd, b_wdata});
    if (iss_valid && (iss_rd != 5'd0)) mpend[iss_rd] = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", rf_we); end
    checks++; if (rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf got rd=%0d wd=%0h exp 0", rf_rd, rf_wdata); end
    checks++; if (fifo_count !== 3'd0 || b_ready !== 1'b1) begin errors++; $display("FAIL reset_fifo got cnt=%0d rdy=%0b exp 0/1", fifo_count, b_ready); end
    checks++; if (hz_rs1 !== 1'b0 || hz_rs2 !== 1'b0) begin errors++; $display("FAIL reset_hz got %0b%0b exp 00", hz_rs1, hz_rs2); end
  endtask

  task automatic test_alu_write();
    a_valid = 1'b1; a_rd = 5'd5; a_wdata = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_write got we=%0b rd=%0d wd=%0h exp 1/5/deadbeef", rf_we, rf_rd, rf_wdata); end
    cycle();
    checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd5) begin errors++; $display("FAIL alu_we_drop got we=%0b rd=%0d exp 0/5", rf_we, rf_rd); end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd7; chk_rs1 = 5'd7; chk_rs2 = 5'd0;
    cycle();
    iss_valid = 1'b0;
    checks++; if (hz_rs1 !== 1'b1 || hz_rs2 !== 1'b0) begin errors++; $display("FAIL sb_set got %0b%0b exp 10", hz_rs1, hz_rs2); end
    b_valid = 1'b1; b_rd = 5'd7; b_wdata = 32'h1234;
    cycle();
    b_valid = 1'b0;
    checks++; if (hz_rs1 !== 1'b1 || rf_we !== 1'b0 || fifo_count !== 3'd1) begin
      errors++; $display("FAIL sb_push got hz=%0b we=%0b cnt=%0d exp 1/0/1", hz_rs1, rf_we, fifo_count); end
    cycle();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h1234 || hz_rs1 !== 1'b0) begin
      errors++; $display("FAIL sb_pop got we=%0b rd=%0d wd=%0h hz=%0b exp 1/7/1234/0", rf_we, rf_rd, rf_wdata, hz_rs1); end
    // Set and clear of the same register in one cycle: set wins.
    iss_valid = 1'b1; iss_rd = 5'd12; chk_rs2 = 5'd12;
    b_valid = 1'b1; b_rd = 5'd12; b_wdata = 32'h55;
    cycle();
    b_valid = 1'b0;
    cycle();
    iss_valid = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd12 || hz_rs2 !== 1'b1) begin
      errors++; $display("FAIL sb_set_wins got we=%0b rd=%0d hz=%0b exp 1/12/1", rf_we, rf_rd, hz_rs2); end
    idle_inputs();
    do_reset();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    a_valid = 1'b1; a_rd = 5'd3; a_wdata = 32'hA0A0;
    for (int i = 0; i < 5; i++) begin
      b_valid = 1'b1; b_rd = 5'(10 + acc); b_wdata = 32'(32'h100 + acc);
      if (b_ready) acc++;
      cycle();
      checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3) begin errors++; $display("FAIL bp_a_wins got we=%0b rd=%0d exp 1/3", rf_we, rf_rd); end
    end
    checks++; if (acc != 4 || b_ready !== 1'b0 || fifo_count !== 3'd4) begin
      errors++; $display("FAIL bp_full got acc=%0d rdy=%0b cnt=%0d exp 4/0/4", acc, b_ready, fifo_count); end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (rf_we !== 1'b1 || rf_rd !== 5'(10 + i) || rf_wdata !== 32'(32'h100 + i)) begin
        errors++; $display("FAIL bp_drain%0d got we=%0b rd=%0d wd=%0h exp 1/%0d/%0h", i, rf_we, rf_rd, rf_wdata, 10 + i, 32'h100 + i); end
    end
    cycle();
    checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL bp_empty got we=%0b cnt=%0d exp 0/0", rf_we, fifo_count); end
  endtask

  task automatic test_full_boundary();
    a_valid = 1'b1; a_rd = 5'd3;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_rd = 5'(20 + i); b_wdata = 32'(i);
      cycle();
    end
    a_valid = 1'b0;
    b_rd = 5'd31; b_wdata = 32'hF00D;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", b_ready); end
    cycle();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd20 || fifo_count !== 3'd3 || b_ready !== 1'b1) begin
      errors++; $display("FAIL full_refuse got we=%0b rd=%0d cnt=%0d rdy=%0b exp 1/20/3/1", rf_we, rf_rd, fifo_count, b_ready); end
    cycle();
    b_valid = 1'b0;
    checks++; if (rf_rd !== 5'd21 || fifo_count !== 3'd3) begin errors++; $display("FAIL full_accept got rd=%0d cnt=%0d exp 21/3", rf_rd, fifo_count); end
    cycle(); cycle(); cycle();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd31 || rf_wdata !== 32'hF00D) begin
      errors++; $display("FAIL full_last got we=%0b rd=%0d wd=%0h exp 1/31/f00d", rf_we, rf_rd, rf_wdata); end
    cycle();
    for (int r = 0; r < 10; r++) begin
      logic [4:0]  rd;
      logic [31:0] wd;
      rd = 5'($urandom_range(1, 31));
      wd = $urandom;
      b_valid = 1'b1; b_rd = rd; b_wdata = wd;
      cycle();
      b_valid = 1'b0;
      cycle();
      checks++; if (rf_we !== 1'b1 || rf_rd !== rd || rf_wdata !== wd) begin
        errors++; $display("FAIL wrap%0d got rd=%0d wd=%0h exp %0d/%0h", r, rf_rd, rf_wdata, rd, wd); end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_zero_rd();
    a_valid = 1'b1; a_rd = 5'd0; a_wdata = 32'h77;
    b_valid = 1'b1; b_rd = 5'd0; b_wdata = 32'h88;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %0b exp 1", b_ready); end
    cycle();
    idle_inputs();
    checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0 || hz_rs1 !== 1'b0) begin
      errors++; $display("FAIL zero_drop got we=%0b cnt=%0d hz=%0b exp 0/0/0", rf_we, fifo_count, hz_rs1); end
  endtask

  task automatic test_async_reset();
    a_valid = 1'b1; a_rd = 5'd3; a_wdata = 32'h3;
    iss_valid = 1'b1; iss_rd = 5'd9; chk_rs1 = 5'd9;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1; b_rd = 5'(24 + i); b_wdata = 32'(i);
      cycle();
      iss_valid = 1'b0;
    end
    checks++; if (fifo_count !== 3'd3 || hz_rs1 !== 1'b1 || rf_we !== 1'b1) begin
      errors++; $display("FAIL ar_pre got cnt=%0d hz=%0b we=%0b exp 3/1/1", fifo_count, hz_rs1, rf_we); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0 || hz_rs1 !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL ar_async got we=%0b cnt=%0d hz=%0b rdy=%0b exp 0/0/0/0", rf_we, fifo_count, hz_rs1, b_ready); end
    idle_inputs();
    chk_rs1 = 5'd9;
    @(posedge clk); #3;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0 || hz_rs1 !== 1'b0) begin
        errors++; $display("FAIL ar_stale%0d got we=%0b cnt=%0d hz=%0b exp 0/0/0", i, rf_we, fifo_count, hz_rs1); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      a_valid   = ($urandom_range(0, 9) < 4);
      a_rd      = 5'($urandom_range(0, 31));
      a_wdata   = $urandom;
      b_valid   = ($urandom_range(0, 9) < 6);
      b_rd      = 5'($urandom_range(0, 31));
      b_wdata   = $urandom;
      iss_valid = ($urandom_range(0, 9) < 3);
      iss_rd    = 5'($urandom_range(0, 31));
      chk_rs1   = 5'($urandom_range(0, 31));
      chk_rs2   = 5'($urandom_range(0, 31));
      #1;
      checks++; if (b_ready !== (mq.size() < DEPTH) || hz_rs1 !== mpend[chk_rs1] || hz_rs2 !== mpend[chk_rs2]) begin
        errors++; $display("FAIL rnd_comb%0d got rdy=%0b hz=%0b%0b exp %0b/%0b%0b", n, b_ready, hz_rs1, hz_rs2,
                           (mq.size() < DEPTH), mpend[chk_rs1], mpend[chk_rs2]); end
      cycle();
      checks++; if (rf_we !== m_we || rf_rd !== m_rd || rf_wdata !== m_wd || fifo_count !== CW'(mq.size())) begin
        errors++; $display("FAIL rnd_rf%0d got we=%0b rd=%0d wd=%0h cnt=%0d exp %0b/%0d/%0h/%0d", n, rf_we, rf_rd, rf_wdata,
                           fifo_count, m_we, m_rd, m_wd, mq.size()); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    test_reset();
    test_alu_write();
    test_scoreboard();
    test_backpressure();
    test_full_boundary();
    test_zero_rd();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
